// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB forwarding, load-use bubble insertion and ALU operand muxing.
// Optional EX_PC_OPERAND_EN adds a registered PC that can replace operand A (AUIPC/JAL).

module id_ex_opnd #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic [RA_W-1:0] ex_rs_i,
   input  logic [XLEN-1:0] ex_data_i,
   input  logic [RA_W-1:0] id_rs_i,
   input  logic [XLEN-1:0] id_data_i,
   input  logic [RA_W-1:0] mem_rd_i,
   input  logic            mem_reg_write_i,
   input  logic [XLEN-1:0] mem_result_i,
   input  logic [RA_W-1:0] wb_rd_i,
   input  logic            wb_reg_write_i,
   input  logic [XLEN-1:0] wb_result_i,
   output logic [XLEN-1:0] fwd_o,
   output logic [XLEN-1:0] cap_data_o
);
   logic mem_hit, wb_hit, wt_hit;

   // x0 is hardwired zero, so a write to it never produces a forwardable value
   assign mem_hit = mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i);
   assign wb_hit  = wb_reg_write_i  && (wb_rd_i  != '0) && (wb_rd_i  == ex_rs_i);
   assign wt_hit  = wb_reg_write_i  && (wb_rd_i  != '0) && (wb_rd_i  == id_rs_i);

   assign fwd_o      = mem_hit ? mem_result_i : (wb_hit ? wb_result_i : ex_data_i);
   assign cap_data_o = wt_hit ? wb_result_i : id_data_i;
endmodule

module id_ex_operand_stage #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic            id_valid_i,
   input  logic [RA_W-1:0] id_rs1_i,
   input  logic [RA_W-1:0] id_rs2_i,
   input  logic [RA_W-1:0] id_rd_i,
   input  logic [XLEN-1:0] id_rs1_data_i,
   input  logic [XLEN-1:0] id_rs2_data_i,
   input  logic [XLEN-1:0] id_imm_i,
   input  logic            id_alu_src_i,
   input  logic [3:0]      id_alu_op_i,
   input  logic            id_reg_write_i,
   input  logic            id_mem_read_i,
`ifdef EX_PC_OPERAND_EN
   input  logic [XLEN-1:0] id_pc_i,
   input  logic            id_a_sel_pc_i,
   output logic [XLEN-1:0] ex_pc_o,
`endif
   input  logic [RA_W-1:0] mem_rd_i,
   input  logic            mem_reg_write_i,
   input  logic [XLEN-1:0] mem_result_i,
   input  logic [RA_W-1:0] wb_rd_i,
   input  logic            wb_reg_write_i,
   input  logic [XLEN-1:0] wb_result_i,
   output logic [3:0]      ALUop_o,
   output logic [XLEN-1:0] ina_o,
   output logic [XLEN-1:0] inb_o,
   output logic            ex_valid_o,
   output logic [RA_W-1:0] ex_rd_o,
   output logic            ex_reg_write_o,
   output logic            ex_mem_read_o,
   output logic [XLEN-1:0] ex_store_data_o,
   output logic            load_use_hazard_o
);
   typedef struct packed {
      logic                      valid;
      logic [RA_W-1:0]           rd;
      logic [1:0][RA_W-1:0]      rs;
      logic [1:0][XLEN-1:0]      data;
      logic [XLEN-1:0]           imm;
      logic                      alu_src;
      logic [3:0]                alu_op;
      logic                      reg_write;
      logic                      mem_read;
`ifdef EX_PC_OPERAND_EN
      logic [XLEN-1:0]           pc;
      logic                      a_sel_pc;
`endif
   } ex_reg_t;

   ex_reg_t ex_q, ex_d;

   logic [1:0][RA_W-1:0] id_rs;
   logic [1:0][XLEN-1:0] id_data, fwd, cap_data;
   logic                 lu_hazard;

   assign id_rs   = {id_rs2_i, id_rs1_i};
   assign id_data = {id_rs2_data_i, id_rs1_data_i};

   for (genvar g = 0; g < 2; g++) begin : g_opnd
      id_ex_opnd #(.XLEN(XLEN), .RA_W(RA_W)) u_opnd (
         .ex_rs_i         (ex_q.rs[g]),
         .ex_data_i       (ex_q.data[g]),
         .id_rs_i         (id_rs[g]),
         .id_data_i       (id_data[g]),
         .mem_rd_i        (mem_rd_i),
         .mem_reg_write_i (mem_reg_write_i),
         .mem_result_i    (mem_result_i),
         .wb_rd_i         (wb_rd_i),
         .wb_reg_write_i  (wb_reg_write_i),
         .wb_result_i     (wb_result_i),
         .fwd_o           (fwd[g]),
         .cap_data_o      (cap_data[g])
      );
   end

   assign lu_hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid_i &&
                      ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));

   always_comb begin
      ex_d = ex_q;
      if (flush_i) begin
         ex_d = '0;
      end else if (stall_i) begin
         // re-latch forwarded values so a producer retiring mid-stall is not lost
         ex_d.data = fwd;
      end else if (lu_hazard) begin
         ex_d = '0;
      end else begin
         ex_d.valid     = id_valid_i;
         ex_d.rd        = id_rd_i;
         ex_d.rs        = id_rs;
         ex_d.data      = cap_data;
         ex_d.imm       = id_imm_i;
         ex_d.alu_src   = id_alu_src_i;
         ex_d.alu_op    = id_alu_op_i;
         ex_d.reg_write = id_reg_write_i && id_valid_i;
         ex_d.mem_read  = id_mem_read_i && id_valid_i;
`ifdef EX_PC_OPERAND_EN
         ex_d.pc        = id_pc_i;
         ex_d.a_sel_pc  = id_a_sel_pc_i;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) ex_q <= '0;
      else          ex_q <= ex_d;
   end

`ifdef EX_PC_OPERAND_EN
   assign ina_o   = ex_q.a_sel_pc ? ex_q.pc : fwd[0];
   assign ex_pc_o = ex_q.pc;
`else
   assign ina_o   = fwd[0];
`endif
   assign inb_o             = ex_q.alu_src ? ex_q.imm : fwd[1];
   assign ex_store_data_o   = fwd[1];
   assign ALUop_o           = ex_q.alu_op;
   assign ex_valid_o        = ex_q.valid;
   assign ex_rd_o           = ex_q.rd;
   assign ex_reg_write_o    = ex_q.reg_write;
   assign ex_mem_read_o     = ex_q.mem_read;
   assign load_use_hazard_o = lu_hazard;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, forwarding priority, load-use, stall refresh, flush, write-through.
module tb_id_ex_operand_stage;
   logic        clk = 1'b0;
   logic        rst_n, stall, flush, id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm;
   logic        id_alu_src, id_reg_write, id_mem_read;
   logic [3:0]  id_alu_op;
`ifdef EX_PC_OPERAND_EN
   logic [31:0] id_pc, ex_pc;
   logic        id_a_sel_pc;
`endif
   logic [4:0]  mem_rd, wb_rd;
   logic        mem_reg_write, wb_reg_write;
   logic [31:0] mem_result, wb_result;
   logic [3:0]  ALUop;
   logic [31:0] ina, inb, ex_store_data;
   logic        ex_valid, ex_reg_write, ex_mem_read, load_use_hazard;
   logic [4:0]  ex_rd;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   id_ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush),
      .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
      .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm),
      .id_alu_src_i(id_alu_src), .id_alu_op_i(id_alu_op), .id_reg_write_i(id_reg_write),
      .id_mem_read_i(id_mem_read),
`ifdef EX_PC_OPERAND_EN
      .id_pc_i(id_pc), .id_a_sel_pc_i(id_a_sel_pc), .ex_pc_o(ex_pc),
`endif
      .mem_rd_i(mem_rd), .mem_reg_write_i(mem_reg_write), .mem_result_i(mem_result),
      .wb_rd_i(wb_rd), .wb_reg_write_i(wb_reg_write), .wb_result_i(wb_result),
      .ALUop_o(ALUop), .ina_o(ina), .inb_o(inb), .ex_valid_o(ex_valid), .ex_rd_o(ex_rd),
      .ex_reg_write_o(ex_reg_write), .ex_mem_read_o(ex_mem_read),
      .ex_store_data_o(ex_store_data), .load_use_hazard_o(load_use_hazard)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance one clock edge; inputs change and outputs are sampled 1ns after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic id_clear();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
      id_alu_src = 0; id_alu_op = 0; id_reg_write = 0; id_mem_read = 0;
`ifdef EX_PC_OPERAND_EN
      id_pc = 0; id_a_sel_pc = 0;
`endif
   endtask

   initial begin
      id_clear();
      stall = 0; flush = 0;
      mem_rd = 0; mem_reg_write = 0; mem_result = 0;
      wb_rd = 0; wb_reg_write = 0; wb_result = 0;

      // 1: reset overrides a valid instruction and stall
      rst_n = 0; stall = 1; id_valid = 1; id_rs1 = 1; id_rs1_data = 32'hDEAD;
      id_alu_op = 4'h5; id_rd = 3; id_reg_write = 1;
      step(); step();
      chk("rst_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst_ina", ina, 32'd0);
      chk("rst_inb", inb, 32'd0);
      chk("rst_aluop", {28'd0, ALUop}, 32'd0);
      chk("rst_rd", {27'd0, ex_rd}, 32'd0);
      chk("rst_ctl", {30'd0, ex_reg_write, ex_mem_read}, 32'd0);
      chk("rst_store", ex_store_data, 32'd0);
      chk("rst_luh", {31'd0, load_use_hazard}, 32'd0);

      // 2: plain capture, then MEM-over-WB forwarding priority
      rst_n = 1; stall = 0; id_clear();
      id_valid = 1; id_rs1 = 3; id_rs1_data = 5; id_rs2 = 0; id_rs2_data = 7;
      id_alu_op = 4'h1; id_rd = 8; id_reg_write = 1;
      step();
      chk("cap_valid", {31'd0, ex_valid}, 32'd1);
      chk("cap_aluop", {28'd0, ALUop}, 32'h1);
      chk("cap_rd", {27'd0, ex_rd}, 32'd8);
      chk("cap_ina", ina, 32'd5);
      chk("cap_inb", inb, 32'd7);
      id_clear();
      mem_rd = 3; mem_reg_write = 1; mem_result = 32'h10;
      wb_rd = 3; wb_reg_write = 1; wb_result = 32'h20;
      #1 chk("fwd_mem_pri", ina, 32'h10);
      mem_reg_write = 0;
      #1 chk("fwd_wb", ina, 32'h20);
      mem_rd = 0; mem_reg_write = 1; mem_result = 32'h99;
      #1 chk("fwd_x0_never", inb, 32'd7);
      mem_reg_write = 0; wb_reg_write = 0; mem_result = 0; wb_result = 0;

      // 3: load-use hazard inserts a bubble; rd=x0 load never triggers it
      id_valid = 1; id_rd = 7; id_mem_read = 1; id_reg_write = 1;
      step();
      chk("ld_memread", {31'd0, ex_mem_read}, 32'd1);
      id_clear(); id_valid = 1; id_rs1 = 1; id_rs2 = 7; id_rd = 2; id_reg_write = 1;
      #1 chk("lu_assert", {31'd0, load_use_hazard}, 32'd1);
      step();
      chk("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
      chk("lu_bub_rw", {31'd0, ex_reg_write}, 32'd0);
      chk("lu_clear", {31'd0, load_use_hazard}, 32'd0);
      id_clear(); id_valid = 1; id_rd = 0; id_mem_read = 1; id_reg_write = 1;
      step();
      id_clear(); id_valid = 1; id_rs2 = 0; id_rs1 = 0; id_rd = 2;
      #1 chk("lu_x0", {31'd0, load_use_hazard}, 32'd0);

      // 4: stall refresh keeps a retiring producer's value
      id_clear(); id_valid = 1; id_rs1 = 4; id_rs1_data = 32'h1111; id_alu_op = 4'h2;
      id_rd = 10; id_reg_write = 1;
      step();
      chk("st_pre", ina, 32'h1111);
      stall = 1; id_alu_op = 4'h9; id_rs1 = 0; id_rs1_data = 0;
      mem_rd = 4; mem_reg_write = 1; mem_result = 32'hABCD;
      #1 chk("st_mem", ina, 32'hABCD);
      step();
      mem_reg_write = 0; mem_rd = 0; mem_result = 0;
      wb_rd = 4; wb_reg_write = 1; wb_result = 32'hABCD;
      #1 chk("st_wb", ina, 32'hABCD);
      chk("st_hold_op", {28'd0, ALUop}, 32'h2);
      step();
      wb_reg_write = 0; wb_rd = 0; wb_result = 0;
      #1 chk("st_gone", ina, 32'hABCD);
      step();
      chk("st_gone2", ina, 32'hABCD);
      stall = 0;
      id_clear(); id_valid = 1; id_rd = 5; id_reg_write = 1; id_alu_op = 4'h6;
      #1 chk("st_release", ina, 32'hABCD);
      step();
      chk("post_cap_valid", {31'd0, ex_valid}, 32'd1);

      // 5: flush wins over stall; immediate selects inb regardless of forwarding
      flush = 1; stall = 1;
      step();
      chk("fl_valid", {31'd0, ex_valid}, 32'd0);
      chk("fl_rw", {31'd0, ex_reg_write}, 32'd0);
      chk("fl_aluop", {28'd0, ALUop}, 32'd0);
      chk("fl_rd", {27'd0, ex_rd}, 32'd0);
      flush = 0; stall = 0;
      id_clear(); id_valid = 1; id_alu_src = 1; id_imm = 32'hFFFF_FFFC;
      id_rs2 = 6; id_rs2_data = 32'h33; id_alu_op = 4'h3;
      step();
      id_clear();
      mem_rd = 6; mem_reg_write = 1; mem_result = 32'h77;
      #1 chk("imm_inb", inb, 32'hFFFF_FFFC);
      chk("imm_store_fwd", ex_store_data, 32'h77);
      mem_reg_write = 0; mem_rd = 0; mem_result = 0;

      // 6: write-through of a WB result at capture
      id_valid = 1; id_rs1 = 9; id_rs1_data = 32'h11;
      wb_rd = 9; wb_reg_write = 1; wb_result = 32'h55;
      step();
      wb_reg_write = 0; wb_result = 0; id_clear();
      #1 chk("wt_ina", ina, 32'h55);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-delivery stage that directly feeds the ALU.
- Registers the decoded instruction fields on each clock.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards and inserts bubbles.
- Presents final ALUop/ina/inb to the ALU one cycle after capture.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
stall  in  1  hold stage contents (downstream backpressure)
flush  in  1  replace captured instruction with bubble (branch mispredict)
id_valid  in  1  ID holds a real instruction
id_rs1, id_rs2, id_rd  in  RA_W  register addresses
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_alu_src  in  1  1: inb = immediate
id_alu_op  in  4  ALU operation code
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
mem_rd  in  RA_W  MEM-stage destination
mem_reg_write  in  1  MEM-stage write enable
mem_result  in  XLEN  MEM-stage ALU result
wb_rd  in  RA_W  WB-stage destination
wb_reg_write  in  1  WB-stage write enable
wb_result  in  XLEN  WB-stage write data
ALUop  out  4  to ALU
ina, inb  out  XLEN  to ALU
ex_valid, ex_rd, ex_reg_write, ex_mem_read  out  1/RA_W/1/1  registered control for EX/MEM
ex_store_data  out  XLEN  forwarded rs2 for stores
load_use_hazard  out  1  combinational; ID must hold its instruction this cycle

Behaviour:
Reset:
- When rst_n is 0 at a clock edge, all registers clear to 0.
- After reset: ex_valid=0, ALUop=0000, ina=inb=0, ex_rd=0, ex_reg_write=0, ex_mem_read=0, ex_store_data=0, load_use_hazard=0.
- Reset overrides stall and flush, including mid-stall.

load_use_hazard:
- Asserts when ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2).

Per-edge priority:
- rst_n low, then flush, then stall, then load_use_hazard, then capture.
- flush: load a bubble (valid=0, reg_write=0, mem_read=0, ALUop=0, rd=0). Flush wins over stall.
- stall: all fields hold, except the rs1/rs2 data registers. These reload with their current forwarded values (fwd_a/fwd_b) so producers retiring during the stall are not lost.
- load_use_hazard (not stalled): load a bubble; ID holds externally.
- capture: all id_* fields registered. ex_valid = id_valid. reg_write and mem_read are gated by id_valid.

Capture write-through:
- If wb_reg_write & wb_rd != 0 & wb_rd == id_rsX, the captured data is wb_result instead of id_rsX_data.

Forwarding (combinational, on registered ex_rs1/ex_rs2):
- fwd_X = mem_result when mem_reg_write & mem_rd != 0 & mem_rd == ex_rsX.
- Otherwise fwd_X = wb_result when wb_reg_write & wb_rd != 0 & wb_rd == ex_rsX.
- Otherwise fwd_X = the registered data.
- MEM has priority over WB. x0 is never forwarded.

Outputs:
- ina = fwd_a.
- inb = ex_alu_src ? ex_imm : fwd_b.
- ex_store_data = fwd_b.
- ALUop = registered alu_op.

Timing:
- Latency is 1 cycle from capture to ALU inputs.
- Throughput is 1 instruction per cycle absent hazards.

Optional Feature:
Macro EX_PC_OPERAND_EN.
- Defined: adds ports id_pc (in, XLEN), id_a_sel_pc (in, 1) and ex_pc (out, XLEN).
  - pc and a_sel_pc are registered with the same stall/flush/bubble rules; bubble and reset value is 0.
  - ina = ex_a_sel_pc ? ex_pc : fwd_a, for AUIPC/JAL.
- Undefined: these ports and registers are absent; ina = fwd_a always.

Test Plan:
1. Reset check: assert rst_n=0 for 2 cycles with id_valid=1 and stall=1 -> ex_valid=0, ina=inb=0, ALUop=0000 after the edge.
2. MEM-over-WB priority: capture add rs1=3 (id_rs1_data=5). Same cycle as EX, set mem_rd=3 with mem_result=0x10 and wb_rd=3 with wb_result=0x20 -> ina=0x10. Drop mem_reg_write -> ina=0x20.
3. Load-use bubble: load with rd=7 in EX (ex_mem_read=1), ID has rs2=7 -> load_use_hazard=1, next cycle ex_valid=0 and ex_reg_write=0. Same case with rd=0 -> load_use_hazard=0.
4. Stall refresh: stall for 3 cycles with ex_rs1=4. Producer x4=0xABCD moves from MEM to WB, then disappears -> ina stays 0xABCD on every cycle, including after release.
5. Flush over stall: flush=1 and stall=1 together -> bubble loaded. Immediate path: id_alu_src=1, id_imm=0xFFFFFFFC -> inb=0xFFFFFFFC regardless of forwarding.
6. Write-through: wb_rd=9 with wb_result=0x55 in the same cycle ID captures rs1=9 with stale data 0x11 -> ina=0x55 after the edge.
